blk_com_dpram_rd_ctrl: RTL

//  Read-side controller for the 32768x34 delay DPRAM (port B). Tracks fill against the

---
 rtl/blk_com_dpram_rd_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/blk_com_dpram_rd_ctrl.sv
// Read-side controller for the delay DPRAM (port B): waits for a programmed fill depth,
// then drains words in address order through a credit-limited skid FIFO onto a stream.
module blk_com_dpram_rd_ctrl #(
    parameter int AW     = 15,
    parameter int DW     = 34,
    parameter int RD_LAT = 2,
    parameter int SKID_D = 4
) (
    input  logic          clkb,
    input  logic          rstb_n,
    input  logic [AW-1:0] cfg_dly,
    input  logic          cfg_en,
    input  logic [AW:0]   wr_ptr,
    output logic          ram_enb,
    output logic [AW-1:0] ram_addrb,
    output logic          ram_rstb,
    input  logic [DW-1:0] ram_doutb,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    input  logic          i_ready,
    output logic [AW:0]   rd_ptr,
    output logic [AW:0]   fill,
    output logic          err_unf,
    output logic          err_ovf,
    output logic [1:0]    dbg_state
);

    // Output stream: o_valid/o_data present a word; it is consumed on the edge where
    // o_valid & i_ready; o_data never changes while o_valid is high and the word is unaccepted.

    localparam int CW = $clog2(SKID_D + 1);
    localparam int IW = (SKID_D > 1) ? $clog2(SKID_D) : 1;
    localparam int UW = $clog2(SKID_D + RD_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            set_unf;
    logic [AW-1:0]   dly_r;
    logic [RD_LAT-1:0] vld_sr;
    logic [DW-1:0]   skid_mem [SKID_D];
    logic [IW-1:0]   wr_idx;
    logic [IW-1:0]   rd_idx;
    logic [CW-1:0]   skid_cnt;
    logic [UW-1:0]   used;
    logic            push;
    logic            pop;

    function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] i);
        return (i == IW'(SKID_D - 1)) ? '0 : i + 1'b1;
    endfunction

    assign fill      = wr_ptr - rd_ptr;
    assign ram_addrb = rd_ptr[AW-1:0];
    assign ram_rstb  = ~rstb_n | (state == ST_FLUSH);
    assign o_valid   = (skid_cnt != '0);
    assign o_data    = skid_mem[rd_idx];
    assign dbg_state = state;
    assign push      = vld_sr[RD_LAT-1];
    assign pop       = o_valid & i_ready;

    // Credits: words already in the skid plus reads still travelling through the RAM.
    always_comb begin
        used = UW'(skid_cnt);
        for (int i = 0; i < RD_LAT; i++) begin
            used = used + UW'(vld_sr[i]);
        end
    end

    assign ram_enb = (state == ST_RUN) && (fill != '0) && (used < UW'(SKID_D));

    always_comb begin
        state_nxt = state;
        set_unf   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_en) state_nxt = ST_FILL;
            end
            ST_FILL: begin
                if (!cfg_en)                    state_nxt = ST_FLUSH;
                else if (fill >= {1'b0, dly_r}) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!cfg_en) begin
                    state_nxt = ST_FLUSH;
                end else if (fill == '0) begin
                    state_nxt = ST_FILL;
                    set_unf   = 1'b1;
                end
            end
            ST_FLUSH: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clkb) begin
        if (!rstb_n) begin
            state    <= ST_IDLE;
            dly_r    <= '0;
            rd_ptr   <= '0;
            vld_sr   <= '0;
            wr_idx   <= '0;
            rd_idx   <= '0;
            skid_cnt <= '0;
            err_unf  <= 1'b0;
            err_ovf  <= 1'b0;
            for (int i = 0; i < SKID_D; i++) skid_mem[i] <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && cfg_en) dly_r <= cfg_dly;
            if (set_unf) err_unf <= 1'b1;
            if (fill[AW] && (fill[AW-1:0] != '0)) err_ovf <= 1'b1;

            if (state == ST_FLUSH) begin
                // Pending returns and buffered words are abandoned; restart at the writer.
                rd_ptr   <= wr_ptr;
                vld_sr   <= '0;
                wr_idx   <= '0;
                rd_idx   <= '0;
                skid_cnt <= '0;
            end else begin
                if (ram_enb) rd_ptr <= rd_ptr + 1'b1;
                vld_sr[0] <= ram_enb;
                for (int i = 1; i < RD_LAT; i++) vld_sr[i] <= vld_sr[i-1];
                if (push) begin
                    skid_mem[wr_idx] <= ram_doutb;
                    wr_idx           <= idx_inc(wr_idx);
                end
                if (pop) rd_idx <= idx_inc(rd_idx);
                case ({push, pop})
                    2'b10:   skid_cnt <= skid_cnt + 1'b1;
                    2'b01:   skid_cnt <= skid_cnt - 1'b1;
                    default: skid_cnt <= skid_cnt;
                endcase
            end
        end
    end

    skid_no_overflow: assert property (@(posedge clkb) disable iff (!rstb_n)
        (push && !pop && state != ST_FLUSH) |-> (skid_cnt < CW'(SKID_D)));

endmodule
